// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared key codes, FSM encoding and the default "PASS" glyph word for the lock controller.
// The default glyph word is also used by the seven-segment decoder downstream.
package keypad_lock_ctrl_pkg;

  localparam logic [3:0]  KEY_CLR       = 4'hE;
  localparam logic [3:0]  KEY_ENT       = 4'hF;
  localparam logic [3:0]  KEY_DIGIT_MAX = 4'h9;
  localparam logic [11:0] PASS_CODE_DEF = 12'hBCC;
  localparam logic [1:0]  DIGITS_MAX    = 2'd3;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_PASS    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_lock_timer.sv
// Lockout duration counter: load clears it, enable counts up, done flags the final cycle.
// Only instantiated when LOCKOUT_TIMEOUT_EN is defined.
module lock_timer #(
  parameter logic [31:0] LIMIT = 32'd500_000_000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = 32'd0;
    else if (en_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = en_i && (cnt_q == LIMIT - 32'd1);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad password controller: assembles 3 BCD digits, checks them against secret, locks out
// after MAX_TRIES misses. LOCKOUT_TIMEOUT_EN adds a timed exit from lockout (LOCK_CYCLES).
module keypad_lock_ctrl
  import keypad_lock_ctrl_pkg::*;
#(
  parameter int          MAX_TRIES   = 6,
`ifdef LOCKOUT_TIMEOUT_EN
  parameter logic [31:0] LOCK_CYCLES = 32'd500_000_000,
`endif
  parameter logic [11:0] PASS_CODE   = PASS_CODE_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [11:0] secret,
  output logic [11:0] data,
  output logic [3:0]  tries,
  output logic [1:0]  times,
  output logic        unlocked,
  output logic        locked_out
);

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_e      state_q, state_d;
  logic [11:0] data_q, data_d;
  logic [3:0]  tries_q, tries_d;
  logic [1:0]  times_q, times_d;
  logic        unlocked_q, unlocked_d;
  logic        locked_q, locked_d;
  logic        tmr_load;
  logic        tmr_done;

`ifdef LOCKOUT_TIMEOUT_EN
  lock_timer #(.LIMIT(LOCK_CYCLES)) u_lock_timer (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .load_i (tmr_load),
    .en_i   (state_q == ST_LOCKOUT),
    .done_o (tmr_done)
  );
`else
  assign tmr_done = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    tries_d    = tries_q;
    times_d    = times_q;
    unlocked_d = unlocked_q;
    locked_d   = locked_q;
    tmr_load   = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            // A full entry ignores further digits rather than shifting the oldest out.
            if (times_q != DIGITS_MAX) begin
              data_d  = {data_q[7:0], key_code};
              times_d = times_q + 2'd1;
            end
          end else if (key_code == KEY_CLR) begin
            data_d  = 12'd0;
            times_d = 2'd0;
          end else if (key_code == KEY_ENT && times_q == DIGITS_MAX) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        data_d  = 12'd0;
        times_d = 2'd0;
        if (data_q == secret) begin
          state_d    = ST_PASS;
          data_d     = PASS_CODE;
          unlocked_d = 1'b1;
          tries_d    = 4'd0;
        end else if (tries_q + 4'd1 >= MAX_T) begin
          state_d  = ST_LOCKOUT;
          tries_d  = MAX_T;
          locked_d = 1'b1;
          tmr_load = 1'b1;
        end else begin
          state_d = ST_ENTRY;
          tries_d = tries_q + 4'd1;
        end
      end

      ST_PASS: begin
        if (key_valid && key_code == KEY_CLR) begin
          state_d    = ST_ENTRY;
          data_d     = 12'd0;
          times_d    = 2'd0;
          unlocked_d = 1'b0;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d  = ST_ENTRY;
          tries_d  = 4'd0;
          locked_d = 1'b0;
          data_d   = 12'd0;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_ENTRY;
      data_q     <= 12'd0;
      tries_q    <= 4'd0;
      times_q    <= 2'd0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      tries_q    <= tries_d;
      times_q    <= times_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  assign data       = data_q;
  assign tries      = tries_q;
  assign times      = times_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed scenarios plus random key traffic against a
// queue-based model of the entry/check/pass/lockout rules.
module tb_keypad_lock_ctrl;

  localparam int MAXT = 6;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [11:0] secret = 12'h123;
  logic [11:0] data;
  logic [3:0]  tries;
  logic [1:0]  times;
  logic        unlocked;
  logic        locked_out;

  int checks = 0;
  int errors = 0;

  keypad_lock_ctrl #(.MAX_TRIES(MAXT), .PASS_CODE(12'hBCC)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .secret     (secret),
    .data       (data),
    .tries      (tries),
    .times      (times),
    .unlocked   (unlocked),
    .locked_out (locked_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=entering, 1=checking, 2=passed, 3=locked out
  int         m_mode = 0;
  logic [3:0] m_digits[$];
  int         m_tries = 0;

  function automatic logic [11:0] m_entry_val();
    logic [11:0] v = 12'd0;
    foreach (m_digits[i]) v = {v[7:0], m_digits[i]};
    return v;
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_mode = 0;
      m_digits.delete();
      m_tries = 0;
    end else begin
      case (m_mode)
        0: if (key_valid) begin
             if (key_code <= 4'd9 && m_digits.size() < 3) m_digits.push_back(key_code);
             else if (key_code == 4'hE) m_digits.delete();
             else if (key_code == 4'hF && m_digits.size() == 3) m_mode = 1;
           end
        1: begin
             if (m_entry_val() == secret) begin
               m_mode = 2;
               m_tries = 0;
             end else begin
               m_tries = m_tries + 1;
               m_mode = (m_tries >= MAXT) ? 3 : 0;
             end
             m_digits.delete();
           end
        2: if (key_valid && key_code == 4'hE) m_mode = 0;
        default: ;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (RSTn) begin
      chk("data",       data,              (m_mode == 2) ? 12'hBCC : (m_mode == 3) ? 12'h000 : m_entry_val());
      chk("tries",      {8'd0, tries},     12'(m_tries));
      chk("times",      {10'd0, times},    12'(m_digits.size()));
      chk("unlocked",   {11'd0, unlocked}, {11'd0, m_mode == 2});
      chk("locked_out", {11'd0, locked_out}, {11'd0, m_mode == 3});
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge CLK);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge CLK);
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RSTn = 1'b0;
    idle(3);
    chk("rst_data", data, 12'h000);
    chk("rst_tries", {8'd0, tries}, 12'h000);
    chk("rst_flags", {9'd0, unlocked, locked_out, times[0] | times[1]}, 12'h000);
    RSTn = 1'b1;
    secret = 12'h123;

    press(4'h1); press(4'h2); press(4'h3);
    #1 chk("lit_entry_data", data, 12'h123);
    chk("lit_entry_times", {10'd0, times}, 12'd3);

    press(4'hF);
    idle(1);
    #1 chk("lit_pass_data", data, 12'hBCC);
    chk("lit_pass_unlocked", {11'd0, unlocked}, 12'd1);
    press(4'h5);
    press(4'hE);
    #1 chk("lit_clr_data", data, 12'h000);
    chk("lit_clr_unlocked", {11'd0, unlocked}, 12'd0);

    press(4'h4); press(4'hF); idle(1);
    #1 chk("lit_early_ent_times", {10'd0, times}, 12'd1);
    press(4'h5); press(4'h6); press(4'h7); press(4'hB);
    #1 chk("lit_no_wrap", data, 12'h456);
    press(4'hE);
    #1 chk("lit_clr_times", {10'd0, times}, 12'd0);

    for (int a = 1; a <= MAXT; a++) begin
      press(4'h9); press(4'h9); press(4'h9); press(4'hF);
      idle(1);
      #1 chk("lit_wrong_tries", {8'd0, tries}, 12'(a));
    end
    chk("lit_locked", {11'd0, locked_out}, 12'd1);
    press(4'h1); press(4'hE); press(4'hF); idle(5);
    #1 chk("lit_lock_hold", {8'd0, tries, 12'h000 == data ? 4'd0 : 4'd1}, 12'h060);

    @(posedge CLK);
    #2 RSTn = 1'b0;
    #1 chk("lit_async_rst", {data[11:2], locked_out, tries != 4'd0}, 12'h000);
    @(negedge CLK);
    RSTn = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if (c % 350 == 349) begin
        RSTn = 1'b0;
        secret = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? 4'hA : 4'($urandom_range(0, 2))};
      end else begin
        int r;
        RSTn = 1'b1;
        r = $urandom_range(0, 15);
        key_valid = ($urandom_range(0, 2) != 0);
        if (r < 8)        key_code = 4'($urandom_range(0, 2));
        else if (r < 11)  key_code = 4'hF;
        else if (r == 11) key_code = 4'hE;
        else if (r == 12) key_code = 4'($urandom_range(10, 13));
        else              key_code = 4'($urandom_range(0, 15));
      end
    end
    key_valid = 1'b0;
    RSTn = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
